// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_W   = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // Misaligned or undefined accesses; unsigned loads have no store form.
  function automatic logic req_illegal(input logic [31:0] addr, input logic [2:0] op,
                                       input logic wen);
    logic bad;
    case (op)
      MEMOP_LB:  bad = 1'b0;
      MEMOP_LBU: bad = wen;
      MEMOP_LH:  bad = (addr[1:0] == 2'b11);
      MEMOP_LHU: bad = (addr[1:0] == 2'b11) || wen;
      MEMOP_W:   bad = (addr[1:0] != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant; remembers the last requester that was accepted.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic accept,
  output logic gnt_id
);

  logic last_q, last_d;

  always_comb begin
    gnt_id = REQ_LSU;
    if (ifu_valid && lsu_valid) begin
      gnt_id = (last_q == REQ_LSU) ? REQ_IFU : REQ_LSU;
    end else if (ifu_valid) begin
      gnt_id = REQ_IFU;
    end
    last_d = accept ? gnt_id : last_q;
  end

  // Reset value makes the LSU win the first contested grant.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= REQ_IFU;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port, one transaction in flight.
// Optional MEM_ARB_ALIGN_CHK_EN: reject misaligned/illegal requests with err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_memop,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_id, accept, resp_hs, in_issue, in_resp;

  mem_arb_rr u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .accept    (accept),
    .gnt_id    (gnt_id)
  );

  assign accept  = (state_q == IDLE) && ((gnt_id == REQ_IFU) ? ifu_req_valid : lsu_req_valid);
  assign resp_hs = (id_q == REQ_IFU) ? ifu_resp_ready : lsu_resp_ready;

`ifdef MEM_ARB_ALIGN_CHK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_ALIGN_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d = gnt_id;
          if (gnt_id == REQ_IFU) begin
            addr_d  = ifu_addr;
            op_d    = MEMOP_W;
            wen_d   = 1'b0;
            wdata_d = '0;
          end else begin
            addr_d  = lsu_addr;
            op_d    = lsu_memop;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
          end
          state_d = ISSUE;
`ifdef MEM_ARB_ALIGN_CHK_EN
          err_d = 1'b0;
          if (req_illegal(addr_d, op_d, wen_d)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
`endif
        end
      end
      ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = wen_q ? 32'd0 : mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MEM_ARB_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Payload registers are only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    id_q    <= id_d;
    addr_q  <= addr_d;
    op_q    <= op_d;
    wen_q   <= wen_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign ifu_req_ready  = (state_q == IDLE) && (gnt_id == REQ_IFU) && ifu_req_valid;
  assign lsu_req_ready  = (state_q == IDLE) && (gnt_id == REQ_LSU) && lsu_req_valid;
  assign ifu_resp_valid = in_resp && (id_q == REQ_IFU);
  assign lsu_resp_valid = in_resp && (id_q == REQ_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
  assign ifu_err        = ifu_resp_valid && err_q;
  assign lsu_err        = lsu_resp_valid && err_q;
`else
  assign ifu_err        = 1'b0;
  assign lsu_err        = 1'b0;
`endif
  assign mem_rd         = in_issue && !wen_q;
  assign mem_wr         = in_issue && wen_q;
  assign mem_addr       = in_issue ? addr_q : '0;
  assign mem_op         = in_issue ? op_q : '0;
  assign mem_wdata      = in_issue ? wdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [2:0]  lsu_memop;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_op;

  int errors = 0;
  int checks = 0;

  // Request payloads and model state shared by the scenario tasks
  logic [31:0] ifu_a, lsu_a, lsu_d, mem_val;
  logic [2:0]  lsu_op;
  bit          lsu_w;
  bit          last_lsu;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_memop(lsu_memop), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] op, input bit w);
`ifdef MEM_ARB_ALIGN_CHK_EN
    if (op == 3'b000) return 1'b0;
    if (op == 3'b100) return w;
    if (op == 3'b001) return a[1:0] == 2'b11;
    if (op == 3'b101) return (a[1:0] == 2'b11) || w;
    if (op == 3'b010) return a[1:0] != 2'b00;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Called in the first cycle after acceptance; returns in the idle cycle after the response.
  task automatic serve(input bit own_lsu, input logic [31:0] a, input logic [2:0] op,
                       input bit w, input logic [31:0] d, input int stall);
    bit          err;
    int          rstart;
    logic [31:0] exp_rdata;
    logic [31:0] got_rdata;
    logic        got_err, got_rv, got_orv;
    err       = model_err(a, op, w);
    rstart    = err ? 1 : 2 + LAT;
    exp_rdata = (err || w) ? 32'd0 : mem_val;
    for (int k = 1; k < rstart + stall + 40; k++) begin
      mem_rdata      = (k == 1 + LAT) ? mem_val : ~mem_val ^ k;
      ifu_resp_ready = !own_lsu && (k >= rstart + stall);
      lsu_resp_ready = own_lsu && (k >= rstart + stall);
      #1;
      checks++;
      if ((ifu_req_ready | lsu_req_ready) !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready k=%0d ifu=%b lsu=%b want 0", k, ifu_req_ready, lsu_req_ready);
      end
      checks++;
      if (mem_rd !== (!err && k == 1 && !w) || mem_wr !== (!err && k == 1 && w)) begin
        errors++;
        $display("FAIL strobe k=%0d rd=%b wr=%b want rd=%b wr=%b", k, mem_rd, mem_wr,
                 !err && k == 1 && !w, !err && k == 1 && w);
      end
      if (!err && k == 1) begin
        checks++;
        if (mem_addr !== a || mem_op !== op || (w && mem_wdata !== d)) begin
          errors++;
          $display("FAIL issue_fields addr=%h op=%b wdata=%h want %h %b %h", mem_addr, mem_op,
                   mem_wdata, a, op, d);
        end
      end
      got_rv    = own_lsu ? lsu_resp_valid : ifu_resp_valid;
      got_orv   = own_lsu ? ifu_resp_valid : lsu_resp_valid;
      got_rdata = own_lsu ? lsu_rdata : ifu_rdata;
      got_err   = own_lsu ? lsu_err : ifu_err;
      checks++;
      if (got_rv !== (k >= rstart) || got_orv !== 1'b0) begin
        errors++;
        $display("FAIL resp_valid k=%0d own=%b other=%b want own=%b other=0", k, got_rv, got_orv,
                 k >= rstart);
      end
      if (k >= rstart) begin
        checks++;
        if (got_rdata !== exp_rdata || got_err !== err) begin
          errors++;
          $display("FAIL resp_data k=%0d rdata=%h err=%b want %h %b", k, got_rdata, got_err,
                   exp_rdata, err);
        end
      end
      if (k == rstart + stall) begin
        tick();
        ifu_resp_ready = 1'b0;
        lsu_resp_ready = 1'b0;
        return;
      end
      tick();
    end
    errors++;
    $display("FAIL serve_timeout no response handshake");
  endtask

  // Present the enabled requests together; check grants and serve each in turn.
  task automatic run_pair(input bit ie, input bit le, input int stall);
    bit pend_i, pend_l, g_l;
    int guard;
    pend_i = ie;
    pend_l = le;
    guard  = 0;
    ifu_addr  = ifu_a;
    lsu_addr  = lsu_a;
    lsu_wen   = lsu_w;
    lsu_memop = lsu_op;
    lsu_wdata = lsu_d;
    while ((pend_i || pend_l) && guard < 8) begin
      guard++;
      ifu_req_valid = pend_i;
      lsu_req_valid = pend_l;
      #1;
      g_l = pend_l && (!pend_i || !last_lsu);
      checks++;
      if (ifu_req_ready !== (pend_i && !g_l) || lsu_req_ready !== g_l) begin
        errors++;
        $display("FAIL grant ifu_ready=%b lsu_ready=%b want %b %b", ifu_req_ready,
                 lsu_req_ready, pend_i && !g_l, g_l);
      end
      checks++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet rd=%b wr=%b irv=%b lrv=%b want 0", mem_rd, mem_wr,
                 ifu_resp_valid, lsu_resp_valid);
      end
      tick();
      last_lsu = g_l;
      if (g_l) pend_l = 1'b0;
      else     pend_i = 1'b0;
      ifu_req_valid = pend_i;
      lsu_req_valid = pend_l;
      if (g_l) serve(1'b1, lsu_a, lsu_op, lsu_w, lsu_d, stall);
      else     serve(1'b0, ifu_a, 3'b010, 1'b0, 32'd0, stall);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ifu_req_ready, ifu_resp_valid, ifu_err, lsu_req_ready, lsu_resp_valid, lsu_err,
         mem_rd, mem_wr} !== 8'd0 || ifu_rdata !== 32'd0 || lsu_rdata !== 32'd0 ||
        mem_addr !== 32'd0 || mem_op !== 3'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL %s outputs not all zero: rv=%b/%b rd=%b wr=%b addr=%h", tag, ifu_resp_valid,
               lsu_resp_valid, mem_rd, mem_wr, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    ifu_addr = 0; lsu_addr = 0; lsu_wen = 0; lsu_memop = 0; lsu_wdata = 0; mem_rdata = 0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    last_lsu = 1'b0;
    tick();
  endtask

  task automatic test_ifu_fetch();
    ifu_a = 32'h8000_0000;
    mem_val = 32'h0000_0413;
    run_pair(1'b1, 1'b0, 0);
  endtask

  task automatic test_round_robin();
    ifu_a = 32'h8000_0010; lsu_a = 32'h8000_0020; lsu_op = 3'b010; lsu_w = 0; lsu_d = 0;
    for (int r = 0; r < 3; r++) begin
      mem_val = $urandom;
      run_pair(1'b1, 1'b1, 0);
    end
  endtask

  task automatic test_lsu_write();
    lsu_a = 32'h8000_0102; lsu_op = 3'b001; lsu_w = 1; lsu_d = 32'h0000_BEEF;
    mem_val = 32'hDEAD_0001;
    run_pair(1'b0, 1'b1, 0);
  endtask

  task automatic test_resp_stall();
    lsu_a = 32'h8000_0040; lsu_op = 3'b010; lsu_w = 0; lsu_d = 0;
    mem_val = 32'h1234_5678;
    run_pair(1'b0, 1'b1, 10);
  endtask

  task automatic test_reset_mid();
    ifu_addr = 32'h8000_0100;
    ifu_req_valid = 1'b1;
    tick();
    ifu_req_valid = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_mid");
    rst_n = 1'b1;
    ifu_resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifu_resp_valid !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL dropped_txn cyc=%0d resp=%b rd=%b wr=%b want 0", i, ifu_resp_valid,
                 mem_rd, mem_wr);
      end
    end
    ifu_resp_ready = 1'b0;
    last_lsu = 1'b0;
    ifu_a = 32'h8000_0104;
    mem_val = 32'h0000_0013;
    run_pair(1'b1, 1'b0, 0);
  endtask

  task automatic test_misaligned();
    lsu_a = 32'h8000_0002; lsu_op = 3'b010; lsu_w = 0; lsu_d = 0;
    mem_val = 32'h5555_AAAA;
    run_pair(1'b0, 1'b1, 1);
  endtask

  task automatic test_random();
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int sel;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(1, 3);
      ifu_a = $urandom;
      if ($urandom_range(0, 3) != 0) ifu_a[1:0] = 2'b00;
      lsu_a = $urandom;
      lsu_op = ops[$urandom_range(0, 4)];
      lsu_w = $urandom_range(0, 1);
      lsu_d = $urandom;
      mem_val = $urandom;
      run_pair(sel[0], sel[1], $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_round_robin();
    test_lsu_write();
    test_resp_stall();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 1, memory read latency in cycles (range 1..15).
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 ifu_req_valid  in  1 / ifu_req_ready  out  1 / ifu_addr  in  32: instruction-fetch request channel, word read only.
REQ-006 ifu_resp_valid  out  1 / ifu_resp_ready  in  1 / ifu_rdata  out  32 / ifu_err  out  1: IFU response channel.
REQ-007 lsu_req_valid  in  1 / lsu_req_ready  out  1 / lsu_addr  in  32 / lsu_wen  in  1 / lsu_memop  in  3 / lsu_wdata  in  32: load/store request channel.
REQ-008 lsu_resp_valid  out  1 / lsu_resp_ready  in  1 / lsu_rdata  out  32 / lsu_err  out  1: LSU response channel.
REQ-009 mem_addr  out  32 / mem_rd  out  1 / mem_wr  out  1 / mem_op  out  3 / mem_wdata  out  32 / mem_rdata  in  32: shared data-memory port, MemOp encoding 000 lb, 001 lh, 010 w, 100 lbu, 101 lhu.

Function
REQ-010 SHALL use FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight.
REQ-011 IDLE: req_ready high only for the granted requester, and only when that requester's valid is high; handshake = valid && ready.
REQ-012 Arbitration SHALL be 2-way round-robin: with both valid, grant the one not granted last; a sole valid requester is granted immediately.
REQ-013 On accept (cycle N), SHALL latch addr/memop/wen/wdata and the requester ID; IFU memop forced to 010, wen forced 0.
REQ-014 ISSUE (cycle N+1): exactly one cycle of mem_rd (read) or mem_wr (write) with latched fields on mem_*; strobes low in all other states.
REQ-015 WAIT: LAT cycles counted down; mem_rdata captured on the final WAIT cycle; writes also pass through WAIT.
REQ-016 RESP from cycle N+2+LAT: resp_valid to the owning requester only, held with stable rdata/err until resp_ready; rdata 0 for writes.
REQ-017 resp_valid && resp_ready SHALL return to IDLE; new request accepted no earlier than the following cycle.
REQ-018 Both req_ready SHALL be low outside IDLE; requester valid held while waiting is legal and SHALL NOT be lost.
REQ-019 resp_ready low SHALL stall in RESP indefinitely with no mem strobe.

Reset
REQ-020 rst_n low at a posedge SHALL force IDLE, round-robin pointer to LSU-first, counter 0, all outputs 0, from the next cycle.
REQ-021 Reset mid-transaction SHALL drop it silently: no response, no further strobe.

Configuration
REQ-022 With MEM_ARB_ALIGN_CHK_EN defined: accepted request with misaligned address (word addr[1:0]!=0; half addr[1:0]==11) or illegal memop (011, 110, 111, or write with 100/101) SHALL skip ISSUE/WAIT, enter RESP at N+1 with err=1, rdata 0, no strobe.
REQ-023 Without MEM_ARB_ALIGN_CHK_EN: err outputs tied 0; every request issued unchanged.

Structure
REQ-024 Package mem_arb_pkg SHALL hold state enum, MemOp constants, requester ID constants.
REQ-025 Sub-module mem_arb_rr SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-026 LAT=1, IFU read 0x80000000, mem_rdata 0x00000413 -> mem_rd at N+1, ifu_resp_valid at N+3, ifu_rdata 0x00000413.
REQ-027 Both valid in same cycle after reset -> LSU granted first, IFU next; repeat -> strict alternation.
REQ-028 LSU write 0x80000102, memop 001, wdata 0xBEEF -> single mem_wr cycle, mem_op 001, lsu_resp_valid with rdata 0.
REQ-029 resp_ready low 10 cycles in RESP -> resp_valid/rdata stable, no strobes, req_ready low throughout.
REQ-030 rst_n low during WAIT -> no response, all outputs 0 next cycle; following IFU request completes normally.
REQ-031 MEM_ARB_ALIGN_CHK_EN, LSU lw 0x80000002 -> no strobe, lsu_err 1 at N+1; without macro -> mem_rd issued, err 0.
